aes_inv_cipher_iter: RTL and testbench

- Iterative AES inverse cipher (FIPS-197 InvCipher). Decrypts one 128-bit block using one inverse round per clock.
- Takes the same flattened expanded key schedule that the encrypt path consumes, so one key-expansion block serves both directions.
- Sits on the decrypt side of the SPI-attached AES core. Uses valid/ready handshakes on both input and output.

---
 rtl/aes_pkg.sv | 101 ++++++++++
 rtl/aes_inv_round.sv | 21 ++
 rtl/aes_inv_cipher_iter.sv | 106 ++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse cipher datapath.
//   - Round-count / key-length constants for AES-128/192/256.
//   - FSM state encoding used by the iterative cipher (IDLE, ROUND, DONE).
//   - Inverse S-box table plus GF(2^8) helpers (xtime, gmul), reduction 0x11B.
//   - Inverse round primitives: InvShiftRows, InvSubBytes, InvMixColumns.
// State layout: byte i of the 128-bit block sits at [127-8i -: 8]; column c
// holds bytes 4c..4c+3, i.e. bits [127-32c -: 32]. Row r of column c is byte 4c+r.
package aes_pkg;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;
    localparam int NK_128 = 4;
    localparam int NK_192 = 6;
    localparam int NK_256 = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_fsm_e;

    // Entry b lives at [2047-8b -: 8].
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Row r rotates right by r columns: out[r][c] = in[r][(c-r) mod 4].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
            o[119-32*c -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
            o[111-32*c -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
            o[103-32*c -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round.
//   state      : current cipher state
//   round_key  : round key added after InvSubBytes
//   is_final   : 1 for the last round (round key 0), which skips InvMixColumns
//   next_state : InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ round_key),
//                or the same without InvMixColumns when is_final=1
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic         is_final,
    output logic [127:0] next_state
);

    logic [127:0] keyed;

    assign keyed      = inv_sub_bytes(inv_shift_rows(state)) ^ round_key;
    assign next_state = is_final ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one inverse round per clock.
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   in_valid    : ciphertext and w presented
//   in_ready    : high only in IDLE
//   ciphertext  : block to decrypt, byte 0 in [127:120]
//   w           : expanded key schedule, round key r at w[r*128 +: 128]
//   out_valid   : plaintext holds a finished result
//   out_ready   : consumer accepts the result
//   plaintext   : decrypted block, registered
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE; out_valid stays high with plaintext held
// until out_ready is seen. in_valid while busy is ignored. w is read live every
// round and must stay stable until out_valid rises; ciphertext is captured.
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int Nr = NR_128,
    parameter int Nk = NK_128
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [127:0]           ciphertext,
    input  logic [128*(Nr+1)-1:0]  w,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [127:0]           plaintext
);

    localparam int RCW = $clog2(Nr + 1);

    if (!((Nr == NR_128 && Nk == NK_128) || (Nr == NR_192 && Nk == NK_192) ||
          (Nr == NR_256 && Nk == NK_256))) begin : g_cfg_err
        $error("aes_inv_cipher_iter: unsupported Nr=%0d / Nk=%0d", Nr, Nk);
    end

    aes_fsm_e       fsm_q, fsm_d;
    logic [RCW-1:0] round_cnt;
    logic [127:0]   state_reg;
    logic [127:0]   round_key;
    logic [127:0]   round_out;
    logic           last_round;

    assign last_round = (round_cnt == '0);
    assign round_key  = w[int'(round_cnt)*128 +: 128];

    aes_inv_round u_round (
        .state      (state_reg),
        .round_key  (round_key),
        .is_final   (last_round),
        .next_state (round_out)
    );

    always_ff @(posedge clk) begin
        if (reset) fsm_q <= IDLE;
        else       fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d    = fsm_q;
        in_ready = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) fsm_d = ROUND;
            end
            ROUND:   if (last_round) fsm_d = DONE;
            DONE:    if (out_ready)  fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            round_cnt <= '0;
            state_reg <= '0;
            plaintext <= '0;
            out_valid <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        // Initial AddRoundKey uses the last round key.
                        state_reg <= ciphertext ^ w[Nr*128 +: 128];
                        round_cnt <= RCW'(Nr - 1);
                    end
                end
                ROUND: begin
                    if (last_round) begin
                        plaintext <= round_out;
                        out_valid <= 1'b1;
                    end else begin
                        state_reg <= round_out;
                        round_cnt <= round_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
module tb_aes_inv_cipher_iter;

    localparam int NR = 10;
    localparam logic [127:0] PT_REF = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic                    reset;
    logic                    in_valid, in_ready, out_valid, out_ready;
    logic [127:0]            ciphertext, plaintext;
    logic [128*(NR+1)-1:0]   w;

    aes_inv_cipher_iter #(.Nr(NR), .Nk(4)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ciphertext(ciphertext), .w(w), .out_valid(out_valid),
        .out_ready(out_ready), .plaintext(plaintext)
    );

    // AES-192 / AES-256 instances for the known-answer vectors.
    logic          k_iv [1:2];
    logic          k_ir [1:2];
    logic          k_ov [1:2];
    logic          k_or;
    logic [127:0]  k_ct [1:2];
    logic [127:0]  k_pt [1:2];
    logic [1919:0] k_w  [1:2];

    aes_inv_cipher_iter #(.Nr(12), .Nk(6)) u_dut192 (
        .clk(clk), .reset(reset), .in_valid(k_iv[1]), .in_ready(k_ir[1]),
        .ciphertext(k_ct[1]), .w(k_w[1][1663:0]), .out_valid(k_ov[1]),
        .out_ready(k_or), .plaintext(k_pt[1])
    );

    aes_inv_cipher_iter #(.Nr(14), .Nk(8)) u_dut256 (
        .clk(clk), .reset(reset), .in_valid(k_iv[2]), .in_ready(k_ir[2]),
        .ciphertext(k_ct[2]), .w(k_w[2]), .out_valid(k_ov[2]),
        .out_ready(k_or), .plaintext(k_pt[2])
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (forward cipher) ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 0; aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // S-box derived from the GF(2^8) inverse plus the affine transform.
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_t[x] = s;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] v);
        return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
    endfunction

    // key is left-aligned in 256 bits; returns round key r at [r*128 +: 128].
    function automatic logic [1919:0] expand_key(input logic [255:0] key, input int nk, input int nr);
        logic [31:0]   wd [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] res;
        rc = 8'h01; res = '0;
        for (int i = 0; i < nk; i++) wd[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = wd[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            wd[i] = wd[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++)
            res[r*128 +: 128] = {wd[4*r], wd[4*r+1], wd[4*r+2], wd[4*r+3]};
        return res;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1919:0] wk, input int nr);
        logic [127:0] s, t;
        logic [7:0]   a0, a1, a2, a3;
        s = pt ^ wk[127:0];
        for (int r = 1; r <= nr; r++) begin
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    t[127-8*(4*c+rr) -: 8] = sbox_t[s[127-8*(4*((c+rr)%4)+rr) -: 8]];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[127-32*c -: 8]; a1 = t[119-32*c -: 8];
                    a2 = t[111-32*c -: 8]; a3 = t[103-32*c -: 8];
                    t[127-32*c -: 8] = mul(a0,8'h02) ^ mul(a1,8'h03) ^ a2 ^ a3;
                    t[119-32*c -: 8] = a0 ^ mul(a1,8'h02) ^ mul(a2,8'h03) ^ a3;
                    t[111-32*c -: 8] = a0 ^ a1 ^ mul(a2,8'h02) ^ mul(a3,8'h03);
                    t[103-32*c -: 8] = mul(a0,8'h03) ^ a1 ^ a2 ^ mul(a3,8'h02);
                end
            end
            s = t ^ wk[r*128 +: 128];
        end
        return s;
    endfunction

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q [$];
    int           acc_q [$];
    logic         prev_ov = 1'b0;
    logic [127:0] mon_exp;
    int           mon_acc;

    always @(negedge clk) begin
        if (reset) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out_valid", out_valid, 0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    mon_acc = acc_q.pop_front();
                    check_eq("plaintext", plaintext, mon_exp);
                    check_eq("latency", cyc - mon_acc, NR + 1);
                end
            end
            prev_ov = out_valid;
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the edge following acceptance.
    task automatic send_block(input logic [127:0] ct, input logic [1407:0] wv,
                              input logic [127:0] exp, output int acc);
        ciphertext = ct;
        w          = wv;
        in_valid   = 1'b1;
        acc        = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(exp);
                acc_q.push_back(cyc);
                acc = cyc;
                break;
            end
        end
        if (acc < 0) check_eq("accept_timeout", in_ready, 1);
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    // Returns at the negedge where out_valid is first seen high.
    task automatic wait_out();
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_eq("out_timeout", out_valid, 1);
    endtask

    task automatic kat_run(input int idx, input int nr, input int nk,
                           input logic [255:0] key, input logic [127:0] ct);
        int   acc;
        logic seen;
        k_w[idx]  = expand_key(key, nk, nr);
        k_ct[idx] = ct;
        k_iv[idx] = 1'b1;
        @(negedge clk);
        check_eq("kat_in_ready", k_ir[idx], 1);
        acc = cyc;
        @(posedge clk); #2;
        k_iv[idx] = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (k_ov[idx]) begin
                check_eq(idx == 1 ? "kat192_latency" : "kat256_latency", cyc - acc, nr + 1);
                check_eq(idx == 1 ? "kat192_plaintext" : "kat256_plaintext", k_pt[idx], PT_REF);
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_eq("kat_timeout", k_ov[idx], 1);
        @(posedge clk); #2;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1919:0] w_c1, wk;
        logic [127:0]  pt, ct;
        logic [255:0]  key;
        int            acc, prev_acc;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        ciphertext = '0; w = '0; k_or = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            k_iv[i] = 1'b0; k_ct[i] = '0; k_w[i] = '0;
        end
        build_sbox();
        w_c1 = expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
        check_eq("model_c1", encrypt(PT_REF, w_c1, 10), CT_C1);

        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_plaintext", plaintext, 0);
        @(posedge clk); #2;

        // AES-128 C.1
        send_block(CT_C1, w_c1[1407:0], PT_REF, acc);
        wait_out();
        @(posedge clk); #2;

        // AES-192 / AES-256 known answers
        kat_run(1, 12, 6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, CT_C2);
        kat_run(2, 14, 8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, CT_C3);

        // Backpressure and busy rejection
        out_ready = 1'b0;
        send_block(CT_C1, w_c1[1407:0], PT_REF, acc);
        ciphertext = 128'hdeadbeef_0badf00d_cafebabe_12345678;
        in_valid   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("busy_in_ready_round", in_ready, 0);
        end
        wait_out();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("hold_out_valid", out_valid, 1);
            check_eq("hold_plaintext", plaintext, PT_REF);
            check_eq("busy_in_ready_done", in_ready, 0);
        end
        @(posedge clk); #2;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("handshake_in_ready", in_ready, 0);
        @(negedge clk);
        check_eq("after_hs_in_ready", in_ready, 1);
        check_eq("after_hs_out_valid", out_valid, 0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check_eq("no_second_block", out_valid, 0);
        end
        @(posedge clk); #2;

        // Reset in round 5, then reapply C.1
        send_block(CT_C1, w_c1[1407:0], PT_REF, acc);
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        exp_q.delete();
        acc_q.delete();
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_in_ready", in_ready, 1);
        check_eq("midrst_plaintext", plaintext, 0);
        @(posedge clk); #2;
        send_block(CT_C1, w_c1[1407:0], PT_REF, acc);
        wait_out();
        @(posedge clk); #2;

        // Round trip: random key/plaintext pairs, back-to-back
        prev_acc = -1;
        for (int i = 0; i < 1000; i++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            wk  = expand_key(key, 4, 10);
            ct  = encrypt(pt, wk, 10);
            send_block(ct, wk[1407:0], pt, acc);
            if (prev_acc >= 0) check_eq("spacing", acc - prev_acc, NR + 2);
            prev_acc = acc;
            wait_out();
            @(posedge clk); #2;
        end

        repeat (4) @(negedge clk);
        check_eq("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
